// File: rtl/pim_mm_cmd_scheduler_if.sv
// Bundle between the matmul command scheduler, its requesters and the PIM engine.
// The slave modport is the scheduler's view; the master modport drives requests and engine done.
interface pim_mm_cmd_scheduler_if #(
    parameter int ADDRESS_LEN = 32,
    parameter int NUM_REQ     = 2,
    parameter int FIFO_DEPTH  = 4
);
    localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [NUM_REQ-1:0]             req_valid;
    logic [NUM_REQ-1:0]             req_ready;
    logic [NUM_REQ*ADDRESS_LEN-1:0] req_src1;
    logic [NUM_REQ*ADDRESS_LEN-1:0] req_src2;
    logic [NUM_REQ*ADDRESS_LEN-1:0] req_dst;
    logic [ADDRESS_LEN-1:0]         eng_src1_addr;
    logic [ADDRESS_LEN-1:0]         eng_src2_addr;
    logic [ADDRESS_LEN-1:0]         eng_dst_addr;
    logic                           eng_start;
    logic                           eng_done;
    logic                           cmp_valid;
    logic [ID_W-1:0]                cmp_id;
    logic                           cmp_timeout;
    logic [CNT_W-1:0]               fifo_count;
    logic                           busy;

    modport slave (
        input  req_valid, req_src1, req_src2, req_dst, eng_done,
        output req_ready, eng_src1_addr, eng_src2_addr, eng_dst_addr, eng_start,
               cmp_valid, cmp_id, cmp_timeout, fifo_count, busy
    );

    modport master (
        output req_valid, req_src1, req_src2, req_dst, eng_done,
        input  req_ready, eng_src1_addr, eng_src2_addr, eng_dst_addr, eng_start,
               cmp_valid, cmp_id, cmp_timeout, fifo_count, busy
    );
endinterface

// File: rtl/pim_mm_cmd_scheduler.sv
// Round-robin command scheduler for the PIM matmul engine: arbitrates requesters into a
// FIFO, then issues one command at a time and reports done or timeout per command.
module pim_mm_cmd_scheduler #(
    parameter int ADDRESS_LEN = 32,
    parameter int NUM_REQ     = 2,
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                    clk,
    input  logic                    rst,
    pim_mm_cmd_scheduler_if.slave   sched_if
);
    localparam int AL    = ADDRESS_LEN;
    localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    typedef struct packed {
        logic [AL-1:0]   src1;
        logic [AL-1:0]   src2;
        logic [AL-1:0]   dst;
        logic [ID_W-1:0] id;
    } entry_t;

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_t;

    logic [AL-1:0] src1_w [NUM_REQ];
    logic [AL-1:0] src2_w [NUM_REQ];
    logic [AL-1:0] dst_w  [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign src1_w[gi] = sched_if.req_src1[gi*AL +: AL];
        assign src2_w[gi] = sched_if.req_src2[gi*AL +: AL];
        assign dst_w[gi]  = sched_if.req_dst[gi*AL +: AL];
    end

    state_t          state_q;
    logic [ID_W-1:0] rr_q, rr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [TMR_W-1:0] timer_q;
    logic [AL-1:0]   src1_q, src2_q, dst_q;
    logic [ID_W-1:0] id_q, cmp_id_q;
    logic            eng_start_q, cmp_valid_q, cmp_timeout_q;

    logic [NUM_REQ-1:0] grant_vec;
    logic [ID_W-1:0]    grant_id;
    logic               found, full, push, pop;
    entry_t             push_entry, head;
    entry_t             mem [FIFO_DEPTH];

    // Search starts at the round-robin pointer and wraps; first valid requester wins.
    always_comb begin
        int idx;
        grant_vec = '0;
        grant_id  = '0;
        found     = 1'b0;
        idx       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && sched_if.req_valid[idx]) begin
                found          = 1'b1;
                grant_id       = ID_W'(idx);
                grant_vec[idx] = 1'b1;
            end
        end
    end

    // Full is taken from the registered count, so a same-cycle pop never frees a slot early.
    assign full               = (count_q == CNT_W'(FIFO_DEPTH));
    assign sched_if.req_ready = full ? '0 : grant_vec;
    assign push               = found && !full;
    assign pop                = (state_q == ST_IDLE) && (count_q != '0);
    assign push_entry         = {src1_w[grant_id], src2_w[grant_id], dst_w[grant_id], grant_id};
    assign head               = mem[rd_ptr_q];

    always_comb begin
        rr_d     = rr_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            rr_d     = (int'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    // Storage carries no reset; the pointers and count alone define what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= push_entry;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            rr_q          <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            timer_q       <= '0;
            src1_q        <= '0;
            src2_q        <= '0;
            dst_q         <= '0;
            id_q          <= '0;
            cmp_id_q      <= '0;
            eng_start_q   <= 1'b0;
            cmp_valid_q   <= 1'b0;
            cmp_timeout_q <= 1'b0;
        end else begin
            rr_q        <= rr_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            eng_start_q <= 1'b0;
            cmp_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (pop) begin
                        src1_q      <= head.src1;
                        src2_q      <= head.src2;
                        dst_q       <= head.dst;
                        id_q        <= head.id;
                        eng_start_q <= 1'b1;
                        state_q     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    timer_q <= '0;
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    timer_q <= timer_q + 1'b1;
                    // A done arriving on the limit cycle still counts as a normal completion.
                    if (sched_if.eng_done) begin
                        cmp_valid_q   <= 1'b1;
                        cmp_timeout_q <= 1'b0;
                        cmp_id_q      <= id_q;
                        state_q       <= ST_IDLE;
                    end else if (timer_q == TMR_W'(TIMEOUT_CYC - 1)) begin
                        cmp_valid_q   <= 1'b1;
                        cmp_timeout_q <= 1'b1;
                        cmp_id_q      <= id_q;
                        state_q       <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign sched_if.eng_src1_addr = src1_q;
    assign sched_if.eng_src2_addr = src2_q;
    assign sched_if.eng_dst_addr  = dst_q;
    assign sched_if.eng_start     = eng_start_q;
    assign sched_if.cmp_valid     = cmp_valid_q;
    assign sched_if.cmp_id        = cmp_id_q;
    assign sched_if.cmp_timeout   = cmp_timeout_q;
    assign sched_if.fifo_count    = count_q;
    assign sched_if.busy          = (state_q != ST_IDLE) || (count_q != '0);
endmodule
